// File: rtl/tdc_hit_sequencer.sv
// TDC hit sequencer: turns a synchronized hit strobe into a capture pulse for
// the delay-line register, waits for the tap encoder, then emits one
// timestamp word {err, coarse, fine} over a valid/ready handshake, followed
// by a programmable dead time.
//
// Build option: define TDC_DROP_CNT_EN to add the saturating drop_cnt output
// counting hits that arrive while busy or while disabled.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | armed; accepts a hit when enable is high
// CAPTURE  | one-cycle capture pulse to the delay-line register
// WAIT_ENC | waits ENC_LAT cycles for fine_index; samples it on the last one
// EMIT     | ts_valid high, ts_data held until ts_ready
// DEAD     | DEAD_CYCLES cycles of hold-off before re-arming

module tdc_hit_sequencer #(
    parameter int COARSE_W    = 24,
    parameter int ENC_LAT     = 1,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                hit,
    output logic                capture,
    input  logic [7:0]          fine_index,
    output logic [COARSE_W+8:0] ts_data,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic                busy
`ifdef TDC_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_ENC,
        S_EMIT,
        S_DEAD
    } state_t;

    // Timer loads are "cycles minus one" so the terminal count is zero.
    localparam logic [7:0] ENC_LOAD  = 8'(ENC_LAT - 1);
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          tmr;
    logic [7:0]          tmr_nxt;
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] coarse_lat;
    logic                accept;
    logic                sample;
    logic                tmr_done;

    assign accept   = (state == S_IDLE) && enable && hit;
    assign tmr_done = (tmr == 8'd0);
    assign capture  = (state == S_CAPTURE);
    assign ts_valid = (state == S_EMIT);
    assign busy     = (state != S_IDLE);

    // Free-running coarse time base; held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse <= '0;
        end else if (enable) begin
            coarse <= coarse + 1'b1;
        end else begin
            coarse <= '0;
        end
    end

    // State and shared phase timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tmr   <= 8'd0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Next-state and timer reload/decrement decisions.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        sample    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_WAIT_ENC;
                tmr_nxt   = ENC_LOAD;
            end
            S_WAIT_ENC: begin
                if (tmr_done) begin
                    sample    = 1'b1;
                    state_nxt = S_EMIT;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            S_EMIT: begin
                if (ts_ready) begin
                    if (DEAD_CYCLES == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DEAD;
                        tmr_nxt   = DEAD_LOAD;
                    end
                end
            end
            S_DEAD: begin
                if (tmr_done) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the coarse time of the accepted hit and build the word once the
    // encoder output is ready; the word then holds until the next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse_lat <= '0;
            ts_data    <= '0;
        end else begin
            if (accept) begin
                coarse_lat <= coarse;
            end
            if (sample) begin
                ts_data <= {(fine_index > 8'd194), coarse_lat, fine_index};
            end
        end
    end

`ifdef TDC_DROP_CNT_EN
    logic drop;

    assign drop = hit && !accept;

    // Saturating count of hits that were not accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
`timescale 1ns/1ps
module tb_tdc_hit_sequencer;

    localparam int CW = 24;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, hit, ts_ready;
    logic [7:0]    fine_index;
    logic          capture, ts_valid, busy;
    logic [CW+8:0] ts_data;

    logic          w_enable, w_hit, w_ready;
    logic [7:0]    w_fine;
    logic          w_capture, w_valid, w_busy;
    logic [WW+8:0] w_data;
`ifdef TDC_DROP_CNT_EN
    logic [15:0]   drop_cnt;
    logic [15:0]   w_drop;
`endif

    always #5 clk = ~clk;

    tdc_hit_sequencer #(.COARSE_W(CW), .ENC_LAT(1), .DEAD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .hit(hit),
        .capture(capture), .fine_index(fine_index), .ts_data(ts_data),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .busy(busy)
`ifdef TDC_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    tdc_hit_sequencer #(.COARSE_W(WW), .ENC_LAT(3), .DEAD_CYCLES(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(w_enable), .hit(w_hit),
        .capture(w_capture), .fine_index(w_fine), .ts_data(w_data),
        .ts_valid(w_valid), .ts_ready(w_ready), .busy(w_busy)
`ifdef TDC_DROP_CNT_EN
        , .drop_cnt(w_drop)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int words    = 0;
    int w_words  = 0;
    int exp_drop = 0;

    logic [CW+8:0] exp_q[$];
    logic [WW+8:0] wexp_q[$];

    // Reference coarse time bases.
    logic [CW-1:0] m_coarse;
    logic [WW-1:0] mw_coarse;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_coarse  <= '0;
            mw_coarse <= '0;
        end else begin
            m_coarse  <= enable   ? m_coarse + 1'b1  : '0;
            mw_coarse <= w_enable ? mw_coarse + 1'b1 : '0;
        end
    end

    // Scoreboard and hold check for the main instance.
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [CW+8:0] prev_d = '0;

    always @(negedge clk) begin
        logic [CW+8:0] e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                n_checks++;
                if (ts_valid !== 1'b1 || ts_data !== prev_d) begin
                    n_fail++;
                    $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", ts_valid, ts_data, prev_d);
                end
            end
            if (ts_valid === 1'b1 && ts_ready === 1'b1) begin
                n_checks++;
                words++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: data=%h, required no word", ts_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ts_data !== e) begin
                        n_fail++;
                        $display("FAIL word: data=%h, required %h", ts_data, e);
                    end
                end
            end
            prev_v = ts_valid;
            prev_r = ts_ready;
            prev_d = ts_data;
        end
    end

    // Scoreboard for the narrow-counter instance.
    always @(negedge clk) begin
        logic [WW+8:0] e;
        if (rst_n && w_valid === 1'b1 && w_ready === 1'b1) begin
            n_checks++;
            w_words++;
            if (wexp_q.size() == 0) begin
                n_fail++;
                $display("FAIL w_unexpected_word: data=%h, required no word", w_data);
            end else begin
                e = wexp_q.pop_front();
                if (w_data !== e) begin
                    n_fail++;
                    $display("FAIL w_word: data=%h, required %h", w_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b, required 0", tag, busy);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (ts_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ts_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_valid_timeout: ts_valid=%b, required 1", tag, ts_valid);
        end
    endtask

    task automatic check_drop(input string tag);
`ifdef TDC_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL %s_drop: drop_cnt=%0d, required %0d", tag, drop_cnt, exp_drop);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; hit = 1'b0; ts_ready = 1'b1; fine_index = 8'd0;
        w_enable = 1'b0; w_hit = 1'b0; w_ready = 1'b1; w_fine = 8'd0;
        repeat (3) step();
        n_checks++;
        if (capture !== 1'b0 || ts_valid !== 1'b0 || busy !== 1'b0 || ts_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: capture=%b valid=%b busy=%b data=%h, required all 0",
                     capture, ts_valid, busy, ts_data);
        end
        n_checks++;
        if (w_valid !== 1'b0 || w_busy !== 1'b0 || w_data !== '0) begin
            n_fail++;
            $display("FAIL reset_w_outputs: valid=%b busy=%b data=%h, required all 0", w_valid, w_busy, w_data);
        end
        check_drop("reset");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int n = 0;
        enable = 1'b1;
        while (m_coarse != 24'd100 && n < 300) begin
            step();
            n++;
        end
        n_checks++;
        if (m_coarse != 24'd100) begin
            n_fail++;
            $display("FAIL basic_reach: coarse model=%0d, required 100", m_coarse);
        end
        hit = 1'b1; fine_index = 8'd37;
        exp_q.push_back({1'b0, 24'd100, 8'd37});
        step(); hit = 1'b0;                          // N+1
        n_checks++;
        if (capture !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_capture: capture=%b busy=%b, required 1 1", capture, busy);
        end
        step();                                      // N+2
        n_checks++;
        if (capture !== 1'b0 || ts_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_n2: capture=%b valid=%b, required 0 0", capture, ts_valid);
        end
        step();                                      // N+3
        n_checks++;
        if (ts_valid !== 1'b1 || ts_data !== {1'b0, 24'd100, 8'd37}) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%b data=%h, required 1 %h", ts_valid, ts_data, {1'b0, 24'd100, 8'd37});
        end
        repeat (4) step();                           // N+7
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_dead: busy=%b, required 1", busy);
        end
        step();                                      // N+8
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic run_word(input logic [7:0] f, input logic err_exp, input string tag);
        wait_idle(tag);
        fine_index = f; hit = 1'b1;
        exp_q.push_back({err_exp, m_coarse, f});
        step(); hit = 1'b0;
        wait_valid(tag);
        n_checks++;
        if (ts_data[CW+8] !== err_exp || ts_data[7:0] !== f) begin
            n_fail++;
            $display("FAIL %s_fields: err=%b fine=%0d, required err=%b fine=%0d", tag, ts_data[CW+8], ts_data[7:0], err_exp, f);
        end
        wait_idle(tag);
    endtask

    task automatic test_err();
        run_word(8'd200, 1'b1, "err200");
        run_word(8'd194, 1'b0, "err194");
        run_word(8'd195, 1'b1, "err195");
        run_word(8'd0,   1'b0, "err0");
    endtask

    task automatic test_backpressure();
        logic [CW+8:0] first;
        int w0;
        ts_ready = 1'b0;
        wait_idle("bp");
        fine_index = 8'd55; hit = 1'b1;
        first = {1'b0, m_coarse, 8'd55};
        exp_q.push_back(first);
        step(); hit = 1'b0;
        wait_valid("bp");
        w0 = words;
        for (int i = 0; i < 10; i++) begin
            hit = 1'b1; exp_drop++;
            step();
            n_checks++;
            if (ts_valid !== 1'b1 || ts_data !== first) begin
                n_fail++;
                $display("FAIL bp_stall%0d: valid=%b data=%h, required 1 %h", i, ts_valid, ts_data, first);
            end
        end
        ts_ready = 1'b1; exp_drop++;                 // hit during handshake cycle
        step(); hit = 1'b0;                          // H+1
        check_drop("bp");
        n_checks++;
        if (words != w0 + 1) begin
            n_fail++;
            $display("FAIL bp_single_word: words=%0d, required %0d", words - w0, 1);
        end
        repeat (3) step();                           // H+4
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_dead: busy=%b, required 1", busy);
        end
        step();                                      // H+5, IDLE re-entered
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_reidle: busy=%b, required 0", busy);
        end
        fine_index = 8'd99; hit = 1'b1;
        exp_q.push_back({1'b0, m_coarse, 8'd99});
        step(); hit = 1'b0;
        n_checks++;
        if (capture !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reentry_accept: capture=%b, required 1", capture);
        end
        wait_idle("bp2");
    endtask

    task automatic test_enable_low();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hit = 1'b1; exp_drop++;
            step();
            n_checks++;
            if (capture !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL en_low%0d: capture=%b busy=%b, required 0 0", i, capture, busy);
            end
        end
        hit = 1'b0;
        check_drop("en_low");
        enable = 1'b1; hit = 1'b1; fine_index = 8'd12;
        exp_q.push_back({1'b0, 24'd0, 8'd12});       // counter cleared while disabled
        step(); hit = 1'b0;
        wait_idle("en_low");
    endtask

    task automatic test_enable_fall();
        int w0;
        step(); step();
        w0 = words;
        fine_index = 8'd77; hit = 1'b1;
        exp_q.push_back({1'b0, m_coarse, 8'd77});
        step(); hit = 1'b0; enable = 1'b0;
        wait_idle("en_fall");
        n_checks++;
        if (words != w0 + 1) begin
            n_fail++;
            $display("FAIL en_fall_word: words=%0d, required 1", words - w0);
        end
        enable = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        int n = 0;
        w_enable = 1'b1; w_ready = 1'b1;
        while (mw_coarse != 4'd15 && n < 40) begin
            step();
            n++;
        end
        w_hit = 1'b1; w_fine = 8'd150;
        wexp_q.push_back({1'b0, 4'd15, 8'd150});
        step(); w_hit = 1'b0;                        // N+1
        n_checks++;
        if (w_capture !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_capture: capture=%b, required 1", w_capture);
        end
        repeat (3) step();                           // N+4
        n_checks++;
        if (w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_early: valid=%b, required 0", w_valid);
        end
        step();                                      // N+5
        n_checks++;
        if (w_valid !== 1'b1 || w_data !== {1'b0, 4'd15, 8'd150}) begin
            n_fail++;
            $display("FAIL wrap_word: valid=%b data=%h, required 1 %h", w_valid, w_data, {1'b0, 4'd15, 8'd150});
        end
        w_hit = 1'b1;                                // handshake cycle: dropped
        step(); w_hit = 1'b0;                        // N+6
        n_checks++;
        if (w_busy !== 1'b0 || w_capture !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_nodead: busy=%b capture=%b, required 0 0", w_busy, w_capture);
        end
        w_hit = 1'b1; w_fine = 8'd201;
        wexp_q.push_back({1'b1, 4'd5, 8'd201});      // 15 + 6 wraps to 5
        step(); w_hit = 1'b0;
        n_checks++;
        if (w_capture !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_reaccept: capture=%b, required 1", w_capture);
        end
        n = 0;
        while (w_busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (w_words != 2) begin
            n_fail++;
            $display("FAIL wrap_words: words=%0d, required 2", w_words);
        end
        w_enable = 1'b0;
    endtask

    task automatic test_reset_mid_emit();
        int w0;
        ts_ready = 1'b0;
        wait_idle("rst");
        fine_index = 8'd5; hit = 1'b1;
        exp_q.push_back({1'b0, m_coarse, 8'd5});
        step(); hit = 1'b0;
        wait_valid("rst");
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        exp_drop = 0;
        #1;
        n_checks++;
        if (ts_valid !== 1'b0 || busy !== 1'b0 || ts_data !== '0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b busy=%b data=%h, required 0 0 0", ts_valid, busy, ts_data);
        end
        check_drop("rst");
        step(); step();
        rst_n = 1'b1; ts_ready = 1'b1;
        w0 = words;
        step();
        n_checks++;
        if (ts_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: valid=%b busy=%b, required 0 0", ts_valid, busy);
        end
        fine_index = 8'd9; hit = 1'b1;
        exp_q.push_back({1'b0, m_coarse, 8'd9});
        step(); hit = 1'b0;
        n_checks++;
        if (capture !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_next_hit: capture=%b, required 1", capture);
        end
        wait_idle("rst2");
        n_checks++;
        if (words != w0 + 1) begin
            n_fail++;
            $display("FAIL rst_words: words=%0d, required 1", words - w0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_backpressure();
        test_enable_low();
        test_enable_fall();
        test_wrap();
        test_reset_mid_emit();
        check_drop("final");
        step();
        n_checks++;
        if (exp_q.size() != 0 || wexp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_words: main=%0d narrow=%0d, required 0 0", exp_q.size(), wexp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_hit_sequencer.md
TDC_HIT_SEQUENCER -- requirements
Module: tdc_hit_sequencer

Interface
REQ-001 Parameter COARSE_W, default 24, width of the free-running coarse counter.
REQ-002 Parameter ENC_LAT, default 1, cycles from capture pulse to valid fine_index (range 1..7).
REQ-003 Parameter DEAD_CYCLES, default 4, dead time after each emitted word (range 0..255).
REQ-004 Port clk  in  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port enable  in  1  arms the sequencer and runs the coarse counter.
REQ-007 Port hit  in  1  synchronized hit strobe; one cycle high per hit.
REQ-008 Port capture  out  1  one-cycle pulse latching the 195-tap delay-line register.
REQ-009 Port fine_index  in  8  binary tap index from the one-hot encoder.
REQ-010 Port ts_data  out  COARSE_W+9  timestamp word {err, coarse[COARSE_W-1:0], fine[7:0]}.
REQ-011 Port ts_valid  out  1  ts_data valid; held until accepted.
REQ-012 Port ts_ready  in  1  downstream accept; transfer when ts_valid and ts_ready both high.
REQ-013 Port busy  out  1  high in every state except IDLE.
REQ-014 Port drop_cnt  out  16  dropped-hit count (present only with TDC_DROP_CNT_EN).

Function
REQ-015 Coarse counter SHALL increment by 1 every cycle enable is high, wrap from 2^COARSE_W-1 to 0, and clear to 0 on the cycle after enable is low.
REQ-016 FSM states SHALL be IDLE, CAPTURE, WAIT_ENC, EMIT, DEAD.
REQ-017 IDLE: on hit=1 and enable=1 in cycle N, coarse value of cycle N SHALL be latched and state SHALL be CAPTURE in cycle N+1.
REQ-018 CAPTURE: capture SHALL be 1 for exactly this one cycle; next state WAIT_ENC.
REQ-019 WAIT_ENC: SHALL last ENC_LAT cycles; fine_index SHALL be sampled on the last of them; next state EMIT.
REQ-020 err bit SHALL be 1 when the sampled fine_index > 194, else 0; fine field SHALL carry the sampled value unmodified.
REQ-021 EMIT: ts_valid=1 with ts_data stable until ts_ready=1; on handshake cycle, next state DEAD (or IDLE if DEAD_CYCLES=0).
REQ-022 DEAD: SHALL last DEAD_CYCLES cycles, then IDLE.
REQ-023 Hit latency: first ts_valid SHALL occur in cycle N+2+ENC_LAT after the hit in cycle N.
REQ-024 A hit arriving in any state other than IDLE, or with enable=0, SHALL be ignored (dropped).
REQ-025 Hit coincident with the handshake cycle in EMIT SHALL be dropped; hit in the cycle IDLE is re-entered SHALL be accepted.
REQ-026 enable falling mid-operation SHALL NOT abort an in-flight word; sequence completes through EMIT/DEAD.
REQ-027 ts_valid SHALL NOT deassert without a handshake.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, coarse counter 0, capture 0, ts_valid 0, ts_data 0, busy 0, drop_cnt 0.
REQ-029 Reset mid-EMIT SHALL discard the pending word; no ts_valid after release until a new hit.
REQ-030 Release of rst_n SHALL be synchronous to clk; first accepted hit one cycle after release.

Configuration
REQ-031 Macro TDC_DROP_CNT_EN defined: drop_cnt port exists, increments by 1 per dropped hit per REQ-024/025, saturates at 16'hFFFF.
REQ-032 Macro TDC_DROP_CNT_EN undefined: drop_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 ENC_LAT=1, DEAD_CYCLES=4, ts_ready=1, hit at N with coarse=100, fine_index=37 -> capture at N+1, ts_valid at N+3, ts_data={0,100,37}, busy low at N+8.
REQ-034 fine_index=200 sampled -> err=1, fine field=200; fine_index=194 -> err=0.
REQ-035 ts_ready held low 10 cycles in EMIT, hits each cycle -> ts_data stable, ts_valid high, drop_cnt +10 (macro on), single word output.
REQ-036 Coarse preset near wrap, COARSE_W=4: hit when counter=15 -> coarse field 15; counter next value 0.
REQ-037 rst_n low in EMIT then high -> ts_valid 0, state IDLE, drop_cnt 0; next hit processed normally.
REQ-038 enable low with hit pulses -> no capture, coarse cleared to 0, drop_cnt increments per hit.
